frame_tx: RTL

- Serial frame transmitter; the sending end of the single-wire link whose receiver does sync detection, address match, 8-bit data capture and CRC-4 check.
- Latches an address and a data byte on a start handshake.
- Serialises, MSB-first, one bit per clock: sync pattern, then address, then data, then CRC-4 of the data.
- Feeds the receiver chain's serial input directly in loopback and system tests.

---
 rtl/frame_tx_if.sv | 25 ++
 rtl/frame_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/frame_tx_if.sv
// rtl/frame_tx_if.sv - start/data handshake and serial status bundle for frame_tx
interface frame_tx_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] addr_in;
    logic [7:0]        data_in;
    logic              tx_out;
    logic              busy;
    logic              ready;
    logic              done;
    logic [3:0]        crc_out;

    // Requester side: issues frames and watches the line and status.
    modport master (
        output start, addr_in, data_in,
        input  tx_out, busy, ready, done, crc_out
    );

    // Transmitter side.
    modport slave (
        input  start, addr_in, data_in,
        output tx_out, busy, ready, done, crc_out
    );
endinterface

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - serial frame transmitter: sync, address, data, CRC-4, MSB-first
module frame_tx #(
    parameter int                SYNC_W     = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 4'b1101,
    parameter int                ADDR_W     = 4,
    parameter int                GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    frame_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SYNC, ADDR, DATA, CRC, GAP} state_t;

    // Sync, address and data travel through one shift register; CRC bits follow from their own.
    localparam int FW      = SYNC_W + ADDR_W + 8;
    localparam int MAX_SA  = (SYNC_W > ADDR_W) ? SYNC_W : ADDR_W;
    localparam int MAX_SAD = (MAX_SA > 8) ? MAX_SA : 8;
    localparam int CNT_MAX = (MAX_SAD > GAP_CYCLES) ? MAX_SAD : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int GAP_END = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(7);
    localparam logic [CW-1:0] CRC_LAST  = CW'(3);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_END);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   frame_sr;
    logic [3:0]      crc_reg;
    logic [2:0]      crc_sr;
    logic            tx_q;
    logic            busy_q;
    logic            ready_q;
    logic            done_q;
    logic [3:0]      crc_out_q;

    // One serial step of x^4+x+1 with the incoming data bit.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    // Frame sequencer: every output is registered so tx_out changes only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_sr  <= '0;
            crc_reg   <= '0;
            crc_sr    <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            crc_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b0;
                    if (bus.start) begin
                        state    <= SYNC;
                        cnt      <= '0;
                        tx_q     <= SYNC_PAT[SYNC_W-1];
                        frame_sr <= {SYNC_PAT[SYNC_W-2:0], bus.addr_in, bus.data_in, 1'b0};
                        crc_reg  <= '0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                SYNC: begin
                    tx_q     <= frame_sr[FW-1];
                    frame_sr <= {frame_sr[FW-2:0], 1'b0};
                    if (cnt == SYNC_LAST) begin
                        state <= ADDR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADDR: begin
                    tx_q     <= frame_sr[FW-1];
                    frame_sr <= {frame_sr[FW-2:0], 1'b0};
                    if (cnt == ADDR_LAST) begin
                        // The bit going out now is data[7], so the CRC starts here.
                        crc_reg <= crc_step(crc_reg, frame_sr[FW-1]);
                        state   <= DATA;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        // All 8 data bits are folded in; start emitting the remainder.
                        tx_q   <= crc_reg[3];
                        crc_sr <= crc_reg[2:0];
                        state  <= CRC;
                        cnt    <= '0;
                    end else begin
                        tx_q     <= frame_sr[FW-1];
                        frame_sr <= {frame_sr[FW-2:0], 1'b0};
                        crc_reg  <= crc_step(crc_reg, frame_sr[FW-1]);
                        cnt      <= cnt + 1'b1;
                    end
                end
                CRC: begin
                    if (cnt == CRC_LAST) begin
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        crc_out_q <= crc_reg;
                        cnt       <= '0;
                        if (GAP_CYCLES == 0) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        tx_q   <= crc_sr[2];
                        crc_sr <= {crc_sr[1:0], 1'b0};
                        cnt    <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    tx_q <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.tx_out  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.crc_out = crc_out_q;
endmodule
